// File: rtl/mem_request_master_pkg.sv
// definesPkg: shared memory-port types, FSM states and the address incrementer
package definesPkg;
  typedef struct packed {
    logic [7:0] Page_reference;
    logic [7:0] Address_code;
  } Taddress;
  typedef struct packed {
    logic [31:0] Data;
  } Tdata_sb;
  typedef enum logic [1:0] {MODIFIED, EXCLUSIVE, SHARED, INVALID} Tmesi_state;
  typedef enum logic [1:0] {IDLE, WRITE, ISSUE, DRAIN} Tstate;
  typedef struct packed {
    Tdata_sb    rdata;
    Tmesi_state mesi;
  } Trsp;
  localparam int DEFAULT_BURST_LEN = 4;
  function automatic Taddress addr_inc(Taddress a);
    return '{Page_reference: a.Page_reference, Address_code: a.Address_code + 8'd1};
  endfunction
endpackage

// File: rtl/mem_request_master_if.sv
// mem_request_master_if: request, response and MainMemory port bundle
interface mem_request_master_if;
  import definesPkg::*;
  logic       req_valid, req_ready, req_we;
  Taddress    req_addr;
  Tdata_sb    req_wdata;
  Tmesi_state req_mesi;
  logic       rsp_valid, rsp_ready;
  Tdata_sb    rsp_rdata;
  Tmesi_state rsp_mesi;
  Taddress    mem_addr;
  Tdata_sb    mem_wdata;
  logic       mem_we;
  Tmesi_state mem_mesi_wr;
  Tdata_sb    mem_rdata;
  Tmesi_state mem_mesi_rd;
  modport master (
    input  req_valid, req_we, req_addr, req_wdata, req_mesi, rsp_ready, mem_rdata, mem_mesi_rd,
    output req_ready, rsp_valid, rsp_rdata, rsp_mesi, mem_addr, mem_wdata, mem_we, mem_mesi_wr
  );
  modport slave (
    output req_valid, req_we, req_addr, req_wdata, req_mesi, rsp_ready, mem_rdata, mem_mesi_rd,
    input  req_ready, rsp_valid, rsp_rdata, rsp_mesi, mem_addr, mem_wdata, mem_we, mem_mesi_wr
  );
endinterface

// File: rtl/mem_request_master_rsp_fifo.sv
// rsp_fifo: response FIFO for read words and their MESI state
module rsp_fifo import definesPkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  Trsp                      i_data,
  input  logic                     i_pop,
  output logic                     o_valid,
  output Trsp                      o_data,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam Trsp RST = '{rdata: '0, mesi: INVALID};
  Trsp          r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_count;
  logic          w_pop;
  assign w_pop   = i_pop && r_count != '0;
  assign o_valid = r_count != '0;
  assign o_data  = r_mem[r_rd];
  assign o_count = r_count;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem   <= '{default: RST};
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      assert (!(i_push && !w_pop && r_count == (AW+1)'(DEPTH)));
      if (i_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/mem_request_master.sv
// mem_request_master: write/burst-read initiator for MainMemory with credited response FIFO
module mem_request_master import definesPkg::*; #(
  parameter int BURST_LEN    = DEFAULT_BURST_LEN,
  parameter int READ_LATENCY = 1,
  parameter int RSP_DEPTH    = 4
) (
  input logic                  clk,
  input logic                  reset,
  mem_request_master_if.master bus
);
  localparam int TW = READ_LATENCY + 1;
  localparam int CW = $clog2(BURST_LEN + 1);
  Tstate                      r_state;
  logic                       r_req_ready, r_we;
  Taddress                    r_addr;
  Tdata_sb                    r_wdata;
  Tmesi_state                 r_mesi_wr;
  logic [CW-1:0]              r_cnt;
  logic [TW-1:0]              r_tag;
  logic [$clog2(RSP_DEPTH):0] w_count;
  logic                       w_credit, w_issue, w_valid;
  Trsp                        w_head, w_push_data;
  // credit covers both queued responses and beats still in the memory pipeline
  assign w_credit    = int'(w_count) + $countones(r_tag) < RSP_DEPTH;
  assign w_issue     = w_credit && ((r_state == IDLE && r_req_ready && bus.req_valid && !bus.req_we) || r_state == ISSUE);
  assign w_push_data = '{rdata: bus.mem_rdata, mesi: bus.mem_mesi_rd};
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_mesi_wr   <= INVALID;
      r_cnt       <= '0;
      r_tag       <= '0;
    end else begin
      r_tag <= TW'({r_tag, w_issue});
      case (r_state)
        IDLE:
          if (r_req_ready && bus.req_valid) begin
            r_req_ready <= 1'b0;
            r_addr      <= bus.req_addr;
            if (bus.req_we) begin
              r_state   <= WRITE;
              r_we      <= 1'b1;
              r_wdata   <= bus.req_wdata;
              r_mesi_wr <= bus.req_mesi;
            end else begin
              r_state <= (w_credit && BURST_LEN == 1) ? DRAIN : ISSUE;
              r_cnt   <= w_credit ? CW'(1) : '0;
            end
          end else r_req_ready <= 1'b1;
        WRITE: begin
          r_we        <= 1'b0;
          r_mesi_wr   <= INVALID;
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
        end
        ISSUE:
          if (w_credit) begin
            // beat 0 may have stalled at accept, in which case its address is already loaded
            r_addr <= r_cnt == '0 ? r_addr : addr_inc(r_addr);
            r_cnt  <= r_cnt + 1'b1;
            if (r_cnt == CW'(BURST_LEN - 1)) r_state <= DRAIN;
          end
        default:
          if (r_tag == '0) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
          end
      endcase
    end
  end
  rsp_fifo #(.DEPTH(RSP_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_tag[TW-1]),
    .i_data  (w_push_data),
    .i_pop   (bus.rsp_ready),
    .o_valid (w_valid),
    .o_data  (w_head),
    .o_count (w_count)
  );
  assign bus.req_ready   = r_req_ready;
  assign bus.rsp_valid   = w_valid;
  assign bus.rsp_rdata   = w_head.rdata;
  assign bus.rsp_mesi    = w_head.mesi;
  assign bus.mem_addr    = r_addr;
  assign bus.mem_wdata   = r_wdata;
  assign bus.mem_we      = r_we;
  assign bus.mem_mesi_wr = r_mesi_wr;
endmodule
